// File: rtl/serial_write_buffer.sv
// Parallel-to-serial output stage: latches a word on start and shifts it out MSB first, one bit per write_sig.
// Optional SERIAL_WRITE_BUF_ERR_EN adds err_sig, pulsed on dropped or over-long start requests.
module serial_write_buffer #(
  parameter int BUF_SIZE = 8,
  localparam int WRITE_COUNT_SIZE = $clog2(BUF_SIZE + 1)
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        write_sig,
  input  logic [BUF_SIZE-1:0]         data_in,
  input  logic [WRITE_COUNT_SIZE-1:0] write_count,
`ifdef SERIAL_WRITE_BUF_ERR_EN
  output logic                        err_sig,
`endif
  output logic                        data_out,
  output logic                        done_sig
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [WRITE_COUNT_SIZE-1:0] BUF_SIZE_W = WRITE_COUNT_SIZE'(BUF_SIZE);

  state_t                      state_reg, state_next;
  logic [BUF_SIZE-1:0]         shift_reg, shift_next;
  logic [WRITE_COUNT_SIZE-1:0] count_reg, count_next;
  logic                        data_out_reg, data_out_next;
  logic                        done_reg, done_next;
  logic [WRITE_COUNT_SIZE-1:0] eff_count;
  logic [BUF_SIZE-1:0]         load_word;

  // Left-align the requested bits so data_in[eff_count-1] lands at the MSB.
  assign eff_count = (write_count > BUF_SIZE_W) ? BUF_SIZE_W : write_count;
  assign load_word = data_in << (BUF_SIZE_W - eff_count);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      count_reg    <= '0;
      data_out_reg <= 1'b0;
      done_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      count_reg    <= count_next;
      data_out_reg <= data_out_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    count_next    = count_reg;
    data_out_next = data_out_reg;
    done_next     = done_reg;
    case (state_reg)
      IDLE: begin
        data_out_next = 1'b0;
        done_next     = 1'b1;
        if (start && (eff_count != '0)) begin
          shift_next    = load_word;
          count_next    = eff_count;
          data_out_next = load_word[BUF_SIZE-1];
          done_next     = 1'b0;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        done_next = 1'b0;
        if (write_sig) begin
          shift_next = shift_reg << 1;
          count_next = count_reg - 1'b1;
          if (count_reg == WRITE_COUNT_SIZE'(1)) begin
            state_next    = IDLE;
            data_out_next = 1'b0;
            done_next     = 1'b1;
          end else begin
            data_out_next = shift_next[BUF_SIZE-1];
          end
        end
      end
      default: begin
        state_next    = IDLE;
        data_out_next = 1'b0;
        done_next     = 1'b1;
      end
    endcase
  end

  assign data_out = data_out_reg;
  assign done_sig = done_reg;

`ifdef SERIAL_WRITE_BUF_ERR_EN
  logic err_reg, err_next;

  // A start while busy is dropped; an over-long count is clamped. Both are flagged.
  assign err_next = start && ((state_reg == SHIFT) || (write_count > BUF_SIZE_W));

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) err_reg <= 1'b0;
    else      err_reg <= err_next;
  end

  assign err_sig = err_reg;
`endif

endmodule

// File: tb/tb_serial_write_buffer.sv
// Bench for serial_write_buffer: directed transfers, expected bits queued by stimulus and checked per strobe.
// Define SERIAL_WRITE_BUF_ERR_EN to also check err_sig pulses.
module tb_serial_write_buffer;
  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       write_sig = 1'b0;
  logic [7:0] data_in = '0;
  logic [3:0] write_count = '0;
  logic       data_out;
  logic       done_sig;
`ifdef SERIAL_WRITE_BUF_ERR_EN
  logic       err_sig;
  int         err_cnt = 0;
`endif

  int   tests = 0;
  int   fails = 0;
  logic exp_q[$];

  serial_write_buffer #(.BUF_SIZE(8)) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .start(start),
    .write_sig(write_sig),
    .data_in(data_in),
    .write_count(write_count),
`ifdef SERIAL_WRITE_BUF_ERR_EN
    .err_sig(err_sig),
`endif
    .data_out(data_out),
    .done_sig(done_sig)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d at %0t", name, act, $time);
    end
  endfunction

  // Monitor: at every strobe the DUT presents either the next queued bit or the idle state.
  always @(negedge sys_clk) begin
    if (rst && write_sig) begin
      if (exp_q.size() > 0) begin
        logic b;
        b = exp_q.pop_front();
        check("bit", int'(data_out), int'(b));
        check("busy_done", int'(done_sig), 0);
      end else begin
        check("idle_out", int'(data_out), 0);
        check("idle_done", int'(done_sig), 1);
      end
    end
`ifdef SERIAL_WRITE_BUF_ERR_EN
    if (err_sig === 1'b1) err_cnt++;
`endif
  end

  task automatic push_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  task automatic do_start(input logic [7:0] d, input logic [3:0] c, input logic with_strobe);
    @(posedge sys_clk); #1;
    start = 1'b1; data_in = d; write_count = c; write_sig = with_strobe;
    @(posedge sys_clk); #1;
    start = 1'b0; write_sig = 1'b0;
    data_in = ~d; write_count = 4'd3;  // later changes must be ignored
  endtask

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (7) @(posedge sys_clk);
      #1 write_sig = 1'b1;
      @(posedge sys_clk);
      #1 write_sig = 1'b0;
    end
  endtask

  task automatic check_done(input string name);
    check({name, "_done"}, int'(done_sig), 1);
    check({name, "_out"}, int'(data_out), 0);
    check({name, "_qempty"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_done", int'(done_sig), 1);
    check("rst_out", int'(data_out), 0);
    rst = 1'b1;

    // 0x3a, 8 bits
    do_start(8'h3a, 4'd8, 1'b0);
    check("first_bit_early", int'(data_out), 0);
    check("start_busy", int'(done_sig), 0);
    push_bits(8'b0011_1010, 8);
    strobe(8);
    check_done("t1");

    // 0x2a, 6 bits, then 0xff, 4 bits
    do_start(8'h2a, 4'd6, 1'b0);
    push_bits(8'b0010_1010, 6);
    strobe(6);
    check_done("t2a");
    do_start(8'hff, 4'd4, 1'b0);
    check("t2b_first", int'(data_out), 1);
    push_bits(8'b0000_1111, 4);
    strobe(4);
    check_done("t2b");

    // reset mid-transfer aborts; strobes afterwards see idle
    do_start(8'h2d, 4'd6, 1'b0);
    push_bits(8'b0010_1101, 6);
    strobe(3);
    @(posedge sys_clk); #3;
    rst = 1'b0;
    #1;
    check("abort_done", int'(done_sig), 1);
    check("abort_out", int'(data_out), 0);
    exp_q.delete();
    @(posedge sys_clk); #1;
    rst = 1'b1;
    strobe(2);
    do_start(8'h0f, 4'd4, 1'b0);
    push_bits(8'b0000_1111, 4);
    strobe(4);
    check_done("t3");

    // zero count: never busy
    do_start(8'hff, 4'd0, 1'b0);
    check("zero_done", int'(done_sig), 1);
    check("zero_out", int'(data_out), 0);
    strobe(2);

    // count 9 clamps to 8
`ifdef SERIAL_WRITE_BUF_ERR_EN
    err_cnt = 0;
`endif
    do_start(8'hc5, 4'd9, 1'b0);
    push_bits(8'b1100_0101, 8);
    strobe(8);
    check_done("clamp");
    strobe(1);
`ifdef SERIAL_WRITE_BUF_ERR_EN
    check("clamp_err", err_cnt, 1);
    err_cnt = 0;
`endif

    // second start mid-transfer is dropped
    do_start(8'h96, 4'd8, 1'b0);
    push_bits(8'b1001_0110, 8);
    strobe(2);
    do_start(8'h0f, 4'd8, 1'b0);
    check("drop_busy", int'(done_sig), 0);
    strobe(6);
    check_done("drop");
    strobe(1);
`ifdef SERIAL_WRITE_BUF_ERR_EN
    check("drop_err", err_cnt, 1);
`endif

    // start and strobe in the same idle cycle: strobe does not shift
    do_start(8'h80, 4'd8, 1'b1);
    check("same_first", int'(data_out), 1);
    push_bits(8'b1000_0000, 8);
    strobe(7);
    check("same_busy7", int'(done_sig), 0);
    strobe(1);
    check_done("same");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_write_buffer.md
Name: serial_write_buffer

Overview:
- Parallel-to-serial output stage; the counterpart that consumes the parallel word produced by the serial read buffer (possibly modified) and re-drives it onto the outgoing serial line.
- Latches up to BUF_SIZE bits on a start pulse and shifts them out MSB first, one bit per write_sig strobe.
- write_sig is a one-cycle strobe from an edge detector on the outgoing data clock, normally the falling edge, so data changes opposite the receiver's sampling edge.
- Signals completion with a level done_sig.

Parameters:
- BUF_SIZE, 8, maximum bits per transfer; width of data_in.
- WRITE_COUNT_SIZE, $clog2(BUF_SIZE+1), derived localparam; width of write_count.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous assert, active-low.
- start  input  1  one-cycle pulse; latch data_in and write_count, begin transfer.
- write_sig  input  1  one-cycle shift strobe, synchronous to sys_clk.
- data_in  input  BUF_SIZE  parallel word; bits [write_count-1:0] are sent.
- write_count  input  WRITE_COUNT_SIZE  number of bits to send.
- data_out  output  1  serial output bit.
- done_sig  output  1  high when idle or finished; low while a transfer is in progress.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit counter=0, data_out=0, done_sig=1. Takes effect immediately, including mid-transfer: the transfer is aborted and no partial bits are resumed.
- States: IDLE, SHIFT.
- IDLE:
  - done_sig=1, data_out=0.
  - write_sig is ignored.
  - On start with eff_count=min(write_count, BUF_SIZE) > 0:
    - load the shift register with data_in left-aligned so that bit data_in[eff_count-1] sits at the MSB;
    - set counter=eff_count;
    - enter SHIFT.
  - On start with write_count=0: stay in IDLE, done_sig stays 1.
- SHIFT:
  - done_sig=0.
  - data_out = shift register MSB, registered. The first bit is valid the cycle after start, i.e. before the first write_sig.
  - Each write_sig: shift left by one, counter decrements.
  - When a write_sig arrives with counter=1: go to IDLE. done_sig=1 and data_out=0 from the next cycle.
  - Total transfer consumes exactly eff_count write_sig strobes. Bit k is held from strobe k to strobe k+1.
- Latency: start -> first bit on data_out = 1 cycle; final strobe -> done_sig high = 1 cycle.
- Simultaneous events:
  - start while in SHIFT: ignored; the transfer continues unchanged.
  - start and write_sig in the same cycle while in IDLE: start wins, and that write_sig does not shift.
  - write_sig while in IDLE: no effect.
- write_count > BUF_SIZE: clamped to BUF_SIZE.
- data_in and write_count are sampled only in the start cycle; later changes have no effect.

Optional Feature:
- Macro: SERIAL_WRITE_BUF_ERR_EN.
- Defined:
  - Adds output port err_sig (1 bit, reset 0).
  - err_sig pulses high for one cycle when start arrives in SHIFT (dropped request).
  - err_sig also pulses high when start arrives with write_count > BUF_SIZE. The clamp still applies.
- Undefined: no err_sig port and no related logic. Behaviour is otherwise identical.

Test Plan:
- Reset, then start with data_in=8'h3a, write_count=8, and 8 write_sig strobes spaced 8 sys_clk apart -> data_out sequence 0,0,1,1,1,0,1,0 (first bit valid before the first strobe); done_sig low throughout, high 1 cycle after the 8th strobe; data_out=0 afterwards.
- start with data_in=8'h2a, write_count=6 -> bits 1,0,1,0,1,0 over 6 strobes. Then start with data_in=8'hff, write_count=4 -> 1,1,1,1, then done_sig=1.
- start with write_count=6, assert rst low for 1 cycle after 3 strobes -> done_sig=1 and data_out=0 immediately. Further strobes produce no output. A fresh start with 4'hf then transmits correctly.
- start with write_count=0 -> done_sig never drops and data_out stays 0. start with write_count=9 (BUF_SIZE=8) -> exactly 8 bits sent; with SERIAL_WRITE_BUF_ERR_EN, err_sig pulses once.
- Second start issued mid-transfer with different data -> original bits continue uninterrupted and the second word is not sent; with SERIAL_WRITE_BUF_ERR_EN, err_sig pulses once.
- start and write_sig in the same IDLE cycle with 8'h80, count 8 -> first bit 1 still held until the next strobe; 8 further strobes are needed to finish.
